// File: rtl/cpu_pkg.sv
// Shared CPU-side types and constants for the instruction-fetch path:
// fetch FSM states, prefetch fault codes and AXI response encodings.
package cpu_pkg;

  localparam int IM_ADDR_LEN = 32;
  localparam int IM_DATA_LEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } fetch_state_e;

  localparam logic [1:0] IMEM_BAD_NONE  = 2'b00;
  localparam logic [1:0] IMEM_BAD_BUS   = 2'b01;
  localparam logic [1:0] IMEM_BAD_RANGE = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Instruction fetches are always secure; only the privilege bit varies.
  function automatic logic [2:0] fetch_arprot(input logic priv_m);
    return {1'b1, 1'b0, priv_m};
  endfunction

endpackage

// File: rtl/imem_axi_bridge_if.sv
// Read-only AXI4-Lite channel bundle (AR + R) between the fetch bridge
// and the interconnect.
interface imem_axi_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] m_araddr;
  logic              m_arvalid;
  logic              m_arready;
  logic [2:0]        m_arprot;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rvalid;
  logic              m_rready;

  modport master (
    output m_araddr, m_arvalid, m_arprot, m_rready,
    input  m_arready, m_rdata, m_rresp, m_rvalid
  );

  modport slave (
    input  m_araddr, m_arvalid, m_arprot, m_rready,
    output m_arready, m_rdata, m_rresp, m_rvalid
  );
endinterface

// File: rtl/imem_axi_bridge.sv
// Bridges the prefetch unit's instruction-memory port onto a read-only
// AXI4-Lite master, one outstanding word fetch, with executable-region filtering.
module imem_axi_bridge
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = IM_ADDR_LEN,
  parameter int                DATA_W   = IM_DATA_LEN,
  parameter logic [ADDR_W-1:0] EXE_BASE = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] EXE_SIZE = 32'h1000_0000
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                imem_req,
  input  logic [ADDR_W-1:0]   imem_addr,
  output logic [DATA_W-1:0]   imem_rdata,
  output logic [1:0]          imem_bad,
  output logic                imem_busy,
  input  logic                priv_m,
  imem_axi_bridge_if.master   m
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [2:0]        arprot_q;
  logic              arvalid_q;
  logic              rready_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        bad_q;

  logic [ADDR_W-1:0] araddr_d;
  logic [ADDR_W-1:0] region_off;
  logic              in_region;
  logic              rresp_err;

  assign araddr_d   = {imem_addr[ADDR_W-1:2], 2'b00};
  // Unsigned wrap makes addresses below EXE_BASE fail the size compare.
  assign region_off = imem_addr - EXE_BASE;
  assign in_region  = (region_off < EXE_SIZE);
  assign rresp_err  = (m.m_rresp == AXI_RESP_SLVERR) || (m.m_rresp == AXI_RESP_DECERR);

  assign imem_busy  = (state_q == ADDR) || (state_q == DATA);
  assign imem_rdata = rdata_q;
  assign imem_bad   = bad_q;
  assign m.m_araddr  = araddr_q;
  assign m.m_arprot  = arprot_q;
  assign m.m_arvalid = arvalid_q;
  assign m.m_rready  = rready_q;

  // NOTE: every register here is updated with <= so all of them see the
  // pre-edge values of each other; a blocking = would create ordering races.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      araddr_q  <= '0;
      arprot_q  <= 3'b100;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rdata_q   <= '0;
      bad_q     <= IMEM_BAD_NONE;
    end else begin
      unique case (state_q)
        IDLE, RESP: begin
          if (imem_req) begin
            araddr_q <= araddr_d;
            arprot_q <= fetch_arprot(priv_m);
            if (in_region) begin
              state_q   <= ADDR;
              arvalid_q <= 1'b1;
            end else begin
              state_q <= RESP;
              rdata_q <= '0;
              bad_q   <= IMEM_BAD_RANGE;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        ADDR: begin
          // arvalid cannot be withdrawn, so the fetch always completes.
          if (m.m_arready) begin
            state_q   <= DATA;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        DATA: begin
          if (m.m_rvalid) begin
            state_q  <= RESP;
            rready_q <= 1'b0;
            rdata_q  <= m.m_rdata;
            bad_q    <= rresp_err ? IMEM_BAD_BUS : IMEM_BAD_NONE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_axi_bridge.sv
// Self-checking bench for imem_axi_bridge: table of fetch vectors with a
// response scoreboard, plus back-to-back and mid-transaction reset sequences.
module tb_imem_axi_bridge;
  import cpu_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic        priv;
    int          ar_wait;
    int          r_wait;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [31:0] exp_araddr;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_bad;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  bad;
    logic [31:0] araddr;
    logic [2:0]  arprot;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [1:0]  imem_bad;
  logic        imem_busy;
  logic        priv_m;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  exp_t sb[$];
  vec_t vecs[9];

  imem_axi_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  imem_axi_bridge dut (
    .clk        (clk),
    .rstn       (rstn),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_bad   (imem_bad),
    .imem_busy  (imem_busy),
    .priv_m     (priv_m),
    .m          (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // The bench slave only raises rvalid while rready is high.
  always @(posedge clk) begin
    if (rstn && bus.m_rvalid && !bus.m_rready) begin
      failures++;
      $display("FAIL rvalid_outside_data actual=1 expected=0 at cycle %0d", cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drives one request in the current cycle, plays the slave, and compares the
  // response against the scoreboard. Returns the cycle in which arvalid first rose.
  task automatic run_fetch(input vec_t v, output int ar_cyc);
    exp_t e;
    int   lat, ar_cnt, r_cnt, start_cyc;
    bit   saw_ar, rv;
    e.rdata  = v.exp_rdata;
    e.bad    = v.exp_bad;
    e.araddr = v.exp_araddr;
    e.arprot = {2'b10, v.priv};
    sb.push_back(e);
    start_cyc = cyc;
    imem_req  = 1'b1;
    imem_addr = v.addr;
    priv_m    = v.priv;
    @(posedge clk); #1;
    imem_req = 1'b0;
    lat = 1; ar_cnt = 0; r_cnt = 0; saw_ar = 1'b0; ar_cyc = -1;
    if (v.exp_bad == IMEM_BAD_RANGE)
      check("arvalid_out_of_region", {31'b0, bus.m_arvalid}, 32'd0);
    while (imem_busy && lat < 64) begin
      imem_req  = 1'b1;
      imem_addr = 32'hFFFF_FFF0;
      priv_m    = ~v.priv;
      if (bus.m_arvalid) begin
        if (!saw_ar) ar_cyc = cyc;
        saw_ar = 1'b1;
        check("araddr_stable", bus.m_araddr, v.exp_araddr);
        check("arprot_stable", {29'b0, bus.m_arprot}, {29'b0, 2'b10, v.priv});
        bus.m_arready = (ar_cnt == v.ar_wait);
        ar_cnt++;
      end
      if (bus.m_rready) begin
        rv = (r_cnt == v.r_wait);
        bus.m_rvalid = rv;
        bus.m_rdata  = rv ? v.rdata : 32'hBAD0_BAD0;
        bus.m_rresp  = rv ? v.rresp : AXI_RESP_DECERR;
        r_cnt++;
      end
      @(posedge clk); #1;
      imem_req      = 1'b0;
      bus.m_arready = 1'b0;
      bus.m_rvalid  = 1'b0;
      lat++;
    end
    check("latency", lat, v.exp_lat);
    if (v.exp_bad != IMEM_BAD_RANGE)
      check("ar_issue_cycle", ar_cyc - start_cyc, 32'd1);
    e = sb.pop_front();
    check("imem_rdata", imem_rdata, e.rdata);
    check("imem_bad", {30'b0, imem_bad}, {30'b0, e.bad});
    check("araddr_latched", bus.m_araddr, e.araddr);
    check("arprot_latched", {29'b0, bus.m_arprot}, {29'b0, e.arprot});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},    {31'b0, imem_busy},     32'd0);
    check({tag, "_rdata"},   imem_rdata,             32'd0);
    check({tag, "_bad"},     {30'b0, imem_bad},      32'd0);
    check({tag, "_arvalid"}, {31'b0, bus.m_arvalid}, 32'd0);
    check({tag, "_rready"},  {31'b0, bus.m_rready},  32'd0);
    check({tag, "_araddr"},  bus.m_araddr,           32'd0);
    check({tag, "_arprot"},  {29'b0, bus.m_arprot},  32'd4);
  endtask

  initial begin
    int ar0, ar1, ar2;
    //            addr          priv ar r  rdata          rresp            araddr         exp_rdata      exp_bad         lat
    vecs[0] = '{32'h0000_0100, 1'b1, 0, 0, 32'h0000_0013, AXI_RESP_OKAY,   32'h0000_0100, 32'h0000_0013, IMEM_BAD_NONE,  3};
    vecs[1] = '{32'h0000_0106, 1'b0, 0, 0, 32'h00A0_0093, AXI_RESP_OKAY,   32'h0000_0104, 32'h00A0_0093, IMEM_BAD_NONE,  3};
    vecs[2] = '{32'h0000_0200, 1'b1, 5, 0, 32'h1234_5678, AXI_RESP_OKAY,   32'h0000_0200, 32'h1234_5678, IMEM_BAD_NONE,  8};
    vecs[3] = '{32'h0000_0300, 1'b0, 0, 2, 32'hCAFE_F00D, AXI_RESP_SLVERR, 32'h0000_0300, 32'hCAFE_F00D, IMEM_BAD_BUS,   5};
    vecs[4] = '{32'h0000_0304, 1'b1, 0, 0, 32'h1111_2222, AXI_RESP_DECERR, 32'h0000_0304, 32'h1111_2222, IMEM_BAD_BUS,   3};
    vecs[5] = '{32'h2000_0000, 1'b1, 0, 0, 32'h5555_5555, AXI_RESP_OKAY,   32'h2000_0000, 32'h0000_0000, IMEM_BAD_RANGE, 1};
    vecs[6] = '{32'h0FFF_FFFE, 1'b0, 1, 1, 32'h8765_4321, AXI_RESP_EXOKAY, 32'h0FFF_FFFC, 32'h8765_4321, IMEM_BAD_NONE,  5};
    vecs[7] = '{32'h1000_0000, 1'b0, 0, 0, 32'h5555_5555, AXI_RESP_OKAY,   32'h1000_0000, 32'h0000_0000, IMEM_BAD_RANGE, 1};
    vecs[8] = '{32'hFFFF_FFFF, 1'b1, 0, 0, 32'h5555_5555, AXI_RESP_OKAY,   32'hFFFF_FFFC, 32'h0000_0000, IMEM_BAD_RANGE, 1};

    rstn = 1'b0;
    imem_req = 1'b0; imem_addr = '0; priv_m = 1'b0;
    bus.m_arready = 1'b0; bus.m_rvalid = 1'b0;
    bus.m_rdata = '0; bus.m_rresp = AXI_RESP_OKAY;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      run_fetch(vecs[i], ar0);
      @(posedge clk); #1;
      check("rdata_hold", imem_rdata, vecs[i].exp_rdata);
      check("bad_hold", {30'b0, imem_bad}, {30'b0, vecs[i].exp_bad});
      check("idle_busy", {31'b0, imem_busy}, 32'd0);
    end

    // Back-to-back: each new request lands in the previous RESP cycle.
    run_fetch(vecs[0], ar0);
    run_fetch(vecs[1], ar1);
    run_fetch(vecs[4], ar2);
    check("b2b_ar_gap1", ar1 - ar0, 32'd3);
    check("b2b_ar_gap2", ar2 - ar1, 32'd3);
    @(posedge clk); #1;

    // Reset asserted while the fetch sits in DATA.
    imem_req = 1'b1; imem_addr = 32'h0000_0400; priv_m = 1'b1;
    @(posedge clk); #1;
    imem_req = 1'b0;
    check("rst_seq_arvalid", {31'b0, bus.m_arvalid}, 32'd1);
    bus.m_arready = 1'b1;
    @(posedge clk); #1;
    bus.m_arready = 1'b0;
    check("rst_seq_rready", {31'b0, bus.m_rready}, 32'd1);
    check("rst_seq_busy", {31'b0, imem_busy}, 32'd1);
    #1 rstn = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    run_fetch(vecs[1], ar0);
    check("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
